// File: rtl/sram_rw_port_ctrl.sv
// RW0-port initiator for a single-port SRAM macro: zero-fills the array after reset,
// then arbitrates valid/ready write and read channels (write wins) with a 2-entry read response FIFO.
module sram_rw_port_ctrl #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 1,
  parameter int DATA_W = 82,
  parameter int MASK_W = 2
) (
  input  logic              clock,
  input  logic              reset,
  output logic              init_done,
  input  logic              w_req_valid,
  output logic              w_req_ready,
  input  logic [ADDR_W-1:0] w_req_addr,
  input  logic [MASK_W-1:0] w_req_mask,
  input  logic [DATA_W-1:0] w_req_data,
  input  logic              r_req_valid,
  output logic              r_req_ready,
  input  logic [ADDR_W-1:0] r_req_addr,
  output logic              r_resp_valid,
  input  logic              r_resp_ready,
  output logic [DATA_W-1:0] r_resp_data,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [MASK_W-1:0] sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  typedef enum logic [1:0] {
    RST_WAIT,
    INIT,
    RUN
  } state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] init_cnt;
  logic              inflight;
  logic [DATA_W-1:0] fifo_mem [2];
  logic              rd_ptr, wr_ptr;
  logic [1:0]        fifo_count;
  logic              w_fire, r_fire, push, pop;
  logic [2:0]        occupancy;

  always_comb begin
    state_next = state;
    case (state)
      RST_WAIT: state_next = INIT;
      INIT:     if (init_cnt == ADDR_W'(DEPTH - 1)) state_next = RUN;
      RUN:      state_next = RUN;
      default:  state_next = RST_WAIT;
    endcase
  end

  assign init_done    = (state == RUN);
  assign r_resp_valid = (fifo_count != 2'd0);
  assign pop          = r_resp_valid && r_resp_ready;
  assign push         = inflight;

  // A read is only accepted if its response has a guaranteed FIFO slot,
  // counting the read already in flight and any entry leaving this cycle.
  assign occupancy   = 3'(inflight) + 3'(fifo_count) - 3'(pop);
  assign w_req_ready = init_done;
  assign r_req_ready = init_done && !w_req_valid && (occupancy < 3'd2);
  assign w_fire      = w_req_valid && w_req_ready;
  assign r_fire      = r_req_valid && r_req_ready;

  assign r_resp_data = r_resp_valid ? fifo_mem[rd_ptr] : '0;

  always_comb begin
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = '0;
    sram_wmask = '0;
    sram_wdata = '0;
    if (state == INIT) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = init_cnt;
      sram_wmask = '1;
    end else if (w_fire) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = w_req_addr;
      sram_wmask = w_req_mask;
      sram_wdata = w_req_data;
    end else if (r_fire) begin
      sram_en    = 1'b1;
      sram_addr  = r_req_addr;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= RST_WAIT;
      init_cnt   <= '0;
      inflight   <= 1'b0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      state      <= state_next;
      init_cnt   <= (state == INIT) ? init_cnt + ADDR_W'(1) : '0;
      inflight   <= r_fire;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      fifo_count <= fifo_count + 2'(push) - 2'(pop);
    end
  end

  // Storage needs no reset: the head is masked to zero while the FIFO is empty.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= sram_rdata;
  end

endmodule

// File: tb/tb_sram_rw_port_ctrl.sv
// Self-checking bench for sram_rw_port_ctrl: behavioural SRAM macro, shadow-array
// scoreboard for read responses, a vector table, and hand-written corner sequences.
module tb_sram_rw_port_ctrl;
  localparam int DEPTH  = 2;
  localparam int ADDR_W = 1;
  localparam int DATA_W = 82;
  localparam int MASK_W = 2;
  localparam int SEG    = DATA_W / MASK_W;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              init_done;
  logic              w_req_valid = 1'b0, w_req_ready;
  logic [ADDR_W-1:0] w_req_addr = '0;
  logic [MASK_W-1:0] w_req_mask = '0;
  logic [DATA_W-1:0] w_req_data = '0;
  logic              r_req_valid = 1'b0, r_req_ready;
  logic [ADDR_W-1:0] r_req_addr = '0;
  logic              r_resp_valid;
  logic              r_resp_ready = 1'b1;
  logic [DATA_W-1:0] r_resp_data;
  logic              sram_en, sram_wmode;
  logic [ADDR_W-1:0] sram_addr;
  logic [MASK_W-1:0] sram_wmask;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  sram_rw_port_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) dut (
    .clock(clock), .reset(reset), .init_done(init_done),
    .w_req_valid(w_req_valid), .w_req_ready(w_req_ready), .w_req_addr(w_req_addr),
    .w_req_mask(w_req_mask), .w_req_data(w_req_data),
    .r_req_valid(r_req_valid), .r_req_ready(r_req_ready), .r_req_addr(r_req_addr),
    .r_resp_valid(r_resp_valid), .r_resp_ready(r_resp_ready), .r_resp_data(r_resp_data),
    .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr),
    .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clock = ~clock;

  // Behavioural RW0 macro: one-cycle read latency, rdata held until the next read.
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_wmode) begin
        for (int s = 0; s < MASK_W; s++)
          if (sram_wmask[s]) mem[sram_addr][s*SEG +: SEG] <= sram_wdata[s*SEG +: SEG];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [DATA_W-1:0] shadow [DEPTH];
  logic [DATA_W-1:0] sb [$];

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && dut.fifo_count == 2'd2 && dut.push && !dut.pop) begin
      errors++;
      $display("FAIL fifo_overflow: push into full response FIFO (cycle %0d)", cyc);
    end
  end

  // Sample handshakes away from the edge, update the reference, then advance one cycle.
  task automatic tick();
    logic [DATA_W-1:0] exp;
    #1;
    if (w_req_valid && w_req_ready)
      for (int s = 0; s < MASK_W; s++)
        if (w_req_mask[s]) shadow[w_req_addr][s*SEG +: SEG] = w_req_data[s*SEG +: SEG];
    if (r_req_valid && r_req_ready) sb.push_back(shadow[r_req_addr]);
    if (r_resp_valid && r_resp_ready) begin
      if (sb.size() == 0) check("unexpected_resp", r_resp_data, '0);
      else begin
        exp = sb.pop_front();
        check("resp_data", r_resp_data, exp);
      end
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending responses expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [MASK_W-1:0] m, input logic [DATA_W-1:0] d);
    w_req_valid = 1'b1; w_req_addr = a; w_req_mask = m; w_req_data = d;
    tick();
    w_req_valid = 1'b0;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a);
    r_req_valid = 1'b1; r_req_addr = a;
    tick();
    r_req_valid = 1'b0;
  endtask

  // Asserts reset (asynchronously, mid-cycle), checks idle outputs, then walks the zero-fill.
  task automatic init_seq();
    reset = 1'b1;
    w_req_valid = 1'b0; r_req_valid = 1'b0; r_resp_ready = 1'b1;
    #1;
    check("rst_ctrl", DATA_W'({init_done, w_req_ready, r_req_ready, r_resp_valid, sram_en, sram_wmode}), '0);
    check("rst_sram_addr_mask", DATA_W'({sram_addr, sram_wmask}), '0);
    check("rst_sram_wdata", sram_wdata, '0);
    check("rst_resp_data", r_resp_data, '0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    sb.delete();
    for (int a = 0; a < DEPTH; a++) shadow[a] = '0;
    #1;
    check("rst_wait_idle", DATA_W'({init_done, sram_en}), '0);
    for (int i = 0; i < DEPTH; i++) begin
      @(posedge clock);
      #1;
      check("init_ctrl", DATA_W'({init_done, sram_en, sram_wmode, sram_wmask}), DATA_W'(5'b0_1_1_11));
      check("init_addr", DATA_W'(sram_addr), DATA_W'(i));
      check("init_wdata", sram_wdata, '0);
    end
    @(posedge clock);
    #1;
    check("init_done", DATA_W'({init_done, w_req_ready, sram_en}), DATA_W'(3'b110));
  endtask

  typedef struct {
    bit                is_wr;
    logic [ADDR_W-1:0] addr;
    logic [MASK_W-1:0] mask;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] exp;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  logic [DATA_W-1:0] val_a, val_b, val_c, val_d;

  initial begin
    for (int a = 0; a < DEPTH; a++) mem[a] = {18'($urandom), $urandom, $urandom};
    sram_rdata = {18'($urandom), $urandom, $urandom};

    vecs[0]  = '{1'b0, 1'b0, 2'b00, '0, '0};
    vecs[1]  = '{1'b0, 1'b1, 2'b00, '0, '0};
    vecs[2]  = '{1'b1, 1'b1, 2'b01, {DATA_W{1'b1}}, '0};
    vecs[3]  = '{1'b0, 1'b1, 2'b00, '0, {41'h0, {41{1'b1}}}};
    vecs[4]  = '{1'b1, 1'b0, 2'b10, {41'h155_5555_5555, 41'h0AA_AAAA_AAAA}, '0};
    vecs[5]  = '{1'b0, 1'b0, 2'b00, '0, {41'h155_5555_5555, 41'h0}};
    vecs[6]  = '{1'b1, 1'b0, 2'b00, {DATA_W{1'b1}}, '0};
    vecs[7]  = '{1'b0, 1'b0, 2'b00, '0, {41'h155_5555_5555, 41'h0}};
    vecs[8]  = '{1'b1, 1'b0, 2'b11, {41'h123_4567_89AB, 41'h0FE_DCBA_9876}, '0};
    vecs[9]  = '{1'b0, 1'b0, 2'b00, '0, {41'h123_4567_89AB, 41'h0FE_DCBA_9876}};
    vecs[10] = '{1'b0, 1'b1, 2'b00, '0, {41'h0, {41{1'b1}}}};

    @(posedge clock);
    #1;
    init_seq();

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].is_wr) begin
        w_req_valid = 1'b1; w_req_addr = vecs[i].addr;
        w_req_mask = vecs[i].mask; w_req_data = vecs[i].data;
        #1;
        check("vec_w_port", DATA_W'({w_req_ready, sram_en, sram_wmode, sram_wmask}),
              DATA_W'({3'b111, vecs[i].mask}));
        check("vec_w_wdata", sram_wdata, vecs[i].data);
        tick();
        w_req_valid = 1'b0;
      end else begin
        r_req_valid = 1'b1; r_req_addr = vecs[i].addr;
        #1;
        check("vec_r_port", DATA_W'({r_req_ready, sram_en, sram_wmode, sram_wmask, sram_addr}),
              DATA_W'({5'b110_00, vecs[i].addr}));
        tick();
        r_req_valid = 1'b0;
        #1;
        check("vec_r_lat1_valid", DATA_W'(r_resp_valid), '0);
        tick();
        #1;
        check("vec_r_lat2_valid", DATA_W'(r_resp_valid), DATA_W'(1));
        check("vec_r_data", r_resp_data, vecs[i].exp);
        tick();
      end
    end

    // Write and read requested together: write wins, read follows next cycle.
    val_d = {18'($urandom), $urandom, $urandom};
    w_req_valid = 1'b1; w_req_addr = 1'b0; w_req_mask = 2'b11; w_req_data = val_d;
    r_req_valid = 1'b1; r_req_addr = 1'b0;
    #1;
    check("arb_ready", DATA_W'({w_req_ready, r_req_ready, sram_wmode}), DATA_W'(3'b101));
    tick();
    w_req_valid = 1'b0;
    #1;
    check("arb_read_next", DATA_W'({r_req_ready, sram_en, sram_wmode}), DATA_W'(3'b110));
    tick();
    r_req_valid = 1'b0;
    drain();

    // Back-pressure: two reads accepted with the consumer stalled, third held off.
    val_a = {18'($urandom), $urandom, $urandom};
    val_b = {18'($urandom), $urandom, $urandom};
    do_write(1'b0, 2'b11, val_a);
    do_write(1'b1, 2'b11, val_b);
    r_resp_ready = 1'b0;
    r_req_valid = 1'b1; r_req_addr = 1'b0;
    #1; check("bp_rd1_ready", DATA_W'(r_req_ready), DATA_W'(1));
    tick();
    r_req_addr = 1'b1;
    #1; check("bp_rd2_ready", DATA_W'(r_req_ready), DATA_W'(1));
    tick();
    r_req_addr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1; check("bp_rd3_stalled", DATA_W'(r_req_ready), '0);
      tick();
    end
    check("bp_full_valid", DATA_W'(r_resp_valid), DATA_W'(1));
    r_resp_ready = 1'b1;
    #1;
    check("bp_head_a", r_resp_data, val_a);
    check("bp_rd3_accept", DATA_W'(r_req_ready), DATA_W'(1));
    tick();
    r_req_valid = 1'b0;
    #1;
    check("bp_next_b", r_resp_data, val_b);
    drain();

    // Read then same-address write next cycle: read keeps the old word.
    val_c = {18'($urandom), $urandom, $urandom};
    do_read(1'b0);
    do_write(1'b0, 2'b11, val_c);
    drain();
    do_read(1'b0);
    tick();
    #1;
    check("order_new_data", r_resp_data, val_c);
    drain();

    // Reset with one FIFO entry and one read in flight.
    r_resp_ready = 1'b0;
    r_req_valid = 1'b1; r_req_addr = 1'b1;
    tick();
    tick();
    r_req_valid = 1'b0;
    #1;
    check("midrst_pre", DATA_W'({r_resp_valid, dut.inflight}), DATA_W'(2'b11));
    init_seq();
    do_read(1'b0);
    do_read(1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sram_rw_port_ctrl.md
# sram_rw_port_ctrl

Initiator for the generated single-port SRAM macros (RW0 port: en / wmode / wmask / wdata / rdata, one-cycle read latency, read data held until the next read). The block turns independent valid/ready write and read request channels into legal RW0 port cycles. It zero-fills the array after reset and returns read data through a 2-entry response FIFO, so a stalled consumer never loses data. It sits between a cache/predictor table controller and one `*_ext` array instance.

## Interface
- DEPTH, 2, number of SRAM words
- ADDR_W, 1, address width, clog2(DEPTH)
- DATA_W, 82, word width
- MASK_W, 2, write-mask bits; segment width DATA_W/MASK_W (41); DATA_W must be a multiple of MASK_W

Ports:
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-high reset
- init_done  out  1  array zero-fill complete
- w_req_valid / w_req_ready  in / out  1  write request handshake
- w_req_addr  in  ADDR_W  write address
- w_req_mask  in  MASK_W  per-segment write enable
- w_req_data  in  DATA_W  write data
- r_req_valid / r_req_ready  in / out  1  read request handshake
- r_req_addr  in  ADDR_W  read address
- r_resp_valid / r_resp_ready  out / in  1  read response handshake
- r_resp_data  out  DATA_W  read data, head of response FIFO
- sram_en  out  1  to RW0_en
- sram_wmode  out  1  to RW0_wmode
- sram_addr  out  ADDR_W  to RW0_addr
- sram_wmask  out  MASK_W  to RW0_wmask
- sram_wdata  out  DATA_W  to RW0_wdata
- sram_rdata  in  DATA_W  from RW0_rdata

## Operation
- FSM states:
  - **RST_WAIT** (reset state): port idle; always advances to INIT on the next cycle.
  - **INIT**: init counter runs 0..DEPTH-1. Each cycle drives sram_en=1, wmode=1, wmask all-ones, wdata=0, addr=counter. After addr DEPTH-1 the FSM goes to RUN.
  - **RUN**: serves requests; no exit except reset.
- init_done = (state==RUN). Both w_req_ready and r_req_ready are 0 outside RUN.
- RUN arbitration: write wins.
  - w_req_ready = RUN.
  - r_req_ready = RUN && !w_req_valid && (inflight + fifo_count − pop) < 2, where pop = r_resp_valid && r_resp_ready in the same cycle.
- Write fire: sram_en=1, wmode=1, addr/wmask/wdata pass through combinationally. A mask of 0 is still issued and leaves the array unchanged.
- Read fire: sram_en=1, wmode=0, addr=r_req_addr, wmask=0, wdata=0. Set the inflight flag.
- No fire: sram_en=0; other sram_* outputs are 0.
- Cycle after a read fire (inflight=1): push sram_rdata into the response FIFO, then clear inflight unless a new read fires.
- Response FIFO: 2 entries, in order. r_resp_valid = fifo_count != 0. Push and pop may occur in the same cycle. Overflow is impossible by construction; verification asserts it.
- Ordering: a write issued in the cycle after a read to the same address does not affect that read's data (captured before the write lands). A read issued after a write returns the new data.

## Timing
- Reset values: state=RST_WAIT, init counter=0, inflight=0, fifo_count=0. All outputs are 0: init_done, both readys, r_resp_valid, and all sram_*. r_resp_data=0.
- Reset deasserted at edge E0: INIT occupies cycles 1..DEPTH after E0; init_done=1 from cycle DEPTH+1.
- Read latency: request fires in cycle t → r_resp_valid=1 in cycle t+2 (FIFO empty case).
- Throughput: one read per cycle sustained while r_resp_ready=1. With r_resp_ready=0, at most 2 reads are accepted before r_req_ready drops.
- Write: one per cycle, effective at the end of the fire cycle.
- Reset mid-operation (asynchronous): FIFO contents and in-flight read are discarded, and the sequence restarts from RST_WAIT, including a full re-zero.

## Test plan
- Reset release → sram_en=1, wmode=1, wmask=2'b11, wdata=0 at addr 0 then addr 1. init_done rises in cycle 3. A read of both addresses afterwards returns 0.
- Write addr1 data 82'h3_FFFF_FFFF_FFFF_FFFF_FFFF mask 2'b01, then read addr1 → r_resp_data low 41 bits all-ones, high 41 bits 0, valid 2 cycles after read fire.
- Simultaneous w_req_valid and r_req_valid → write fires, r_req_ready=0. The read fires the following cycle.
- r_resp_ready=0, back-to-back reads of addr0 and addr1 (after writing A, B) → 2 accepted, third stalled. Raising ready drains A then B in order, and the third read is then accepted.
- Read addr0 (holding A) in cycle t, write C to addr0 in t+1 → response = A. Next read of addr0 → C.
- Assert reset while the FIFO holds 1 entry and a read is in flight → r_resp_valid=0 immediately. Re-init occurs and init_done returns after DEPTH+1 cycles.
